// File: rtl/reset_text_pkg.sv
// Shared constants for the reset/game-over text overlay: character codes,
// text-area geometry, banner strings and the 8-to-40 pixel row expander.
package reset_text_pkg;

   localparam int TEXT_COLS = 14;
   localparam int TEXT_ROWS = 2;
   localparam int CELL_PX   = 40;
   localparam int SCALE     = 5;

   localparam logic [7:0] CH_SPACE = 8'h20;
   localparam logic [7:0] CH_A     = 8'h41;
   localparam logic [7:0] CH_E     = 8'h45;
   localparam logic [7:0] CH_G     = 8'h47;
   localparam logic [7:0] CH_I     = 8'h49;
   localparam logic [7:0] CH_M     = 8'h4D;
   localparam logic [7:0] CH_N     = 8'h4E;
   localparam logic [7:0] CH_O     = 8'h4F;
   localparam logic [7:0] CH_P     = 8'h50;
   localparam logic [7:0] CH_R     = 8'h52;
   localparam logic [7:0] CH_S     = 8'h53;
   localparam logic [7:0] CH_T     = 8'h54;
   localparam logic [7:0] CH_U     = 8'h55;
   localparam logic [7:0] CH_V     = 8'h56;
   localparam logic [7:0] CH_W     = 8'h57;
   localparam logic [7:0] CH_Y     = 8'h59;

   // Packed string: element TEXT_COLS-1 holds the leftmost character.
   typedef logic [TEXT_COLS-1:0][7:0] text_row_t;

   localparam text_row_t STR_GAME_OVER = "  GAME  OVER  ";
   localparam text_row_t STR_YOU_WIN   = "   YOU  WIN   ";
   localparam text_row_t STR_PRESS_R   = "PRESS R RESET ";

   function automatic logic [7:0] char_at(input logic [3:0] row,
                                          input logic [3:0] col,
                                          input logic       game_over,
                                          input logic       victory);
      logic [3:0] idx;
      idx     = 4'(TEXT_COLS - 1) - col;
      char_at = CH_SPACE;
      if (int'(col) < TEXT_COLS) begin
         if (row == 4'd0) begin
            if (game_over)    char_at = STR_GAME_OVER[idx];
            else if (victory) char_at = STR_YOU_WIN[idx];
         end else if (row == 4'd1) begin
            if (game_over || victory) char_at = STR_PRESS_R[idx];
         end
      end
   endfunction

   // Each font bit becomes SCALE output pixels; font bit 7 lands on 39..35.
   function automatic logic [CELL_PX-1:0] expand_row(input logic [7:0] g);
      expand_row = '0;
      for (int i = 0; i < 8; i++)
         expand_row[i*SCALE +: SCALE] = {SCALE{g[i]}};
   endfunction

endpackage

// File: rtl/reset_text_provider_if.sv
// Character-generator bus between the video timing logic and the text provider.
interface reset_text_provider_if;
   logic [7:0]  char_yx;
   logic [7:0]  char_line;
   logic        vsync_in;
   logic        game_over_in;
   logic        victory_in;
   logic [39:0] char_pixels;

   modport slave (
      input  char_yx, char_line, vsync_in, game_over_in, victory_in,
      output char_pixels
   );

   modport master (
      output char_yx, char_line, vsync_in, game_over_in, victory_in,
      input  char_pixels
   );
endinterface

// File: rtl/reset_text_provider_font_rom.sv
// Combinational 8x8 font for the banner character set; unmapped codes are blank.
module font_rom_8x8
   import reset_text_pkg::*;
(
   input  logic [7:0] code_i,
   input  logic [2:0] row_i,
   output logic [7:0] bits_o
);

   logic [63:0] glyph;

   // Glyph row 0 is the top byte.
   always_comb begin
      glyph = 64'h0;
      unique case (code_i)
         CH_A: glyph = 64'h183C66667E666600;
         CH_E: glyph = 64'h7E60607C60607E00;
         CH_G: glyph = 64'h3C66606E66663C00;
         CH_I: glyph = 64'h3C18181818183C00;
         CH_M: glyph = 64'h63777F6B63636300;
         CH_N: glyph = 64'h66767E7E6E666600;
         CH_O: glyph = 64'h3C66666666663C00;
         CH_P: glyph = 64'h7C66667C60606000;
         CH_R: glyph = 64'h7C66667C786C6600;
         CH_S: glyph = 64'h3C66603C06663C00;
         CH_T: glyph = 64'h7E18181818181800;
         CH_U: glyph = 64'h6666666666663C00;
         CH_V: glyph = 64'h66666666663C1800;
         CH_W: glyph = 64'h6363636B7F776300;
         CH_Y: glyph = 64'h6666663C18181800;
         default: glyph = 64'h0;
      endcase
   end

   assign bits_o = glyph[{~row_i, 3'b111} -: 8];

endmodule

// File: rtl/reset_text_provider.sv
// Two-stage text overlay: stage 1 picks the character, stage 2 emits its glyph row.
// Optional row-1 blink is built when RESET_TEXT_BLINK_EN is defined.
module reset_text_provider
   import reset_text_pkg::*;
(
   input  logic                  pclk,
   input  logic                  rst,
   reset_text_provider_if.slave  bus
);

   logic [7:0]         code_d, code_q;
   logic [CELL_PX-1:0] pix_d, pix_q;
   logic [2:0]         glyph_row;
   logic [7:0]         glyph_bits;
   logic               line_ok;
   logic               blank;

   assign code_d    = char_at(bus.char_yx[7:4], bus.char_yx[3:0],
                              bus.game_over_in, bus.victory_in);
   assign line_ok   = bus.char_line < 8'(CELL_PX);
   assign glyph_row = 3'(bus.char_line / 8'(SCALE));

   font_rom_8x8 u_font (
      .code_i (code_q),
      .row_i  (glyph_row),
      .bits_o (glyph_bits)
   );

`ifdef RESET_TEXT_BLINK_EN
   logic       row1_d, row1_q;
   logic       vs_q;
   logic [5:0] blink_d, blink_q;

   assign row1_d  = bus.char_yx[7:4] == 4'd1;
   assign blink_d = (bus.vsync_in && !vs_q) ? blink_q + 6'd1 : blink_q;
   assign blank   = row1_q && blink_q[5];

   always_ff @(posedge pclk or posedge rst) begin
      if (rst) begin
         row1_q  <= 1'b0;
         vs_q    <= 1'b0;
         blink_q <= '0;
      end else begin
         row1_q  <= row1_d;
         vs_q    <= bus.vsync_in;
         blink_q <= blink_d;
      end
   end
`else
   assign blank = 1'b0;
`endif

   assign pix_d = (line_ok && !blank) ? expand_row(glyph_bits) : '0;

   // Async reset clears the output immediately, even mid-line.
   always_ff @(posedge pclk or posedge rst) begin
      if (rst) begin
         code_q <= CH_SPACE;
         pix_q  <= '0;
      end else begin
         code_q <= code_d;
         pix_q  <= pix_d;
      end
   end

   assign bus.char_pixels = pix_q;

endmodule

// File: doc/reset_text_provider.md
RESET_TEXT_PROVIDER -- requirements
Module: reset_text_provider

Interface
REQ-001 SHALL have port: pclk  input  1  pixel clock; all registers update on its rising edge.
REQ-002 SHALL have port: rst  input  1  reset; asynchronous, active-high.
REQ-003 SHALL have port: char_yx  input  8  text cell address; [7:4] = row, [3:0] = column.
REQ-004 SHALL have port: char_line  input  8  pixel line within the 40-pixel cell, range 0..39.
REQ-005 SHALL have port: vsync_in  input  1  frame sync; used only by the blink counter.
REQ-006 SHALL have port: game_over_in  input  1  selects the GAME OVER banner.
REQ-007 SHALL have port: victory_in  input  1  selects the YOU WIN banner.
REQ-008 SHALL have port: char_pixels  output  40  glyph row; bit 39 is the leftmost pixel.

Function
REQ-009 SHALL define a text area of 14 columns x 2 rows of 40x40-pixel cells.
REQ-010 Row 0 SHALL hold the 14-character string "  GAME  OVER  " when game_over_in=1.
REQ-011 Row 0 SHALL hold "   YOU  WIN   " when game_over_in=0 and victory_in=1.
REQ-012 Row 0 SHALL be all spaces when neither flag is set; game_over_in has priority when both are set.
REQ-013 Row 1 SHALL hold "PRESS R RESET " whenever either flag is set, and spaces otherwise.
REQ-014 Any row >= 2 or column >= 14 SHALL map to the space character (all-zero pixels).
REQ-015 Stage 1 SHALL register the character code selected by char_yx and the flags.
REQ-016 Stage 2 SHALL register the glyph row built from the stage-1 code and the current char_line.
REQ-017 Latency SHALL be 2 cycles from char_yx to char_pixels and 1 cycle from char_line to char_pixels.
REQ-018 The glyph row index SHALL be char_line/5 (range 0..7), read from an 8x8 font.
REQ-019 Each font bit SHALL be replicated to 5 adjacent output bits; font bit 7 SHALL map to bits 39..35.
REQ-020 char_line >= 40 SHALL produce char_pixels = 0 on the following cycle.
REQ-021 The font SHALL contain glyphs for space, A, E, G, I, M, N, O, P, R, S, T, U, V, W, Y; an unmapped code SHALL yield 0.

Reset
REQ-022 On rst=1: char_pixels = 0, stage-1 code = space, blink counter = 0 and vsync edge register = 0, all applied immediately.
REQ-023 The first valid output after rst deasserts SHALL appear 2 cycles after the first char_yx sample.
REQ-024 A rst assertion mid-line SHALL force char_pixels to 0 within the same cycle, with no partial glyph output.

Configuration
REQ-025 When macro RESET_TEXT_BLINK_EN is defined, a 6-bit counter SHALL increment on each vsync_in rising edge and wrap from 63 to 0.
REQ-026 With RESET_TEXT_BLINK_EN defined, row-1 cells SHALL output 0 while counter[5]=1; row 0 SHALL be unaffected.
REQ-027 Without RESET_TEXT_BLINK_EN, no counter SHALL be built and row 1 SHALL always be shown as specified in REQ-013.

Structure
REQ-028 Package reset_text_pkg SHALL hold the character-code constants, TEXT_COLS=14, TEXT_ROWS=2, CELL_PX=40, SCALE=5, and the three strings.
REQ-029 Sub-module font_rom_8x8 SHALL map (code, row 0..7) to an 8-bit glyph row; it is combinational and registered by the parent in stage 2.
REQ-030 The implementation SHALL fit within 120-400 lines of RTL, with no block RAM required.

Verification
REQ-031 Reset: rst=1 for 3 cycles with any inputs -> char_pixels=0 throughout and on the first cycle after release.
REQ-032 GAME OVER: game_over_in=1, char_yx=8'h02 then char_line=0 next cycle -> 2 cycles after char_yx, char_pixels equals the 'G' row 0 bits each expanded x5.
REQ-033 Priority: game_over_in=1 and victory_in=1, char_yx=8'h03 -> output matches 'Y' glyph for victory=0 case? no: matches 'A' ("  GAME..."), not 'Y'/space of the win string.
REQ-034 Bounds: char_yx=8'h0E, then 8'h20, then char_line=45 with a valid cell -> char_pixels=0 in all three cases.
REQ-035 Blink (RESET_TEXT_BLINK_EN defined): after 32 vsync rising edges, char_yx=8'h10 -> 0; after 64 edges -> the 'P' glyph row; char_yx=8'h02 -> 'G' glyph row at both points.
REQ-036 Latency: step char_yx every cycle across a full row 0..13 -> char_pixels sequence equals the expected glyph sequence delayed by exactly 2 cycles.
